// File: rtl/rdma_req_arbiter.sv
// rdma_req_arbiter: round-robin merge of N_ID RDMA request streams into one
// registered output, with per-requester tracking of outstanding completions.
module rdma_req_arbiter #(
    parameter  int N_ID     = 4,
    parameter  int MAX_OUTS = 32,
    localparam int ID_BITS  = (N_ID <= 1) ? 1 : $clog2(N_ID),
    localparam int CNT_BITS = $clog2(MAX_OUTS + 1)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_ID-1:0]            s_req_valid,
    output logic [N_ID-1:0]            s_req_ready,
    input  logic [N_ID*256-1:0]        s_req_data,
    output logic                       m_req_valid,
    input  logic                       m_req_ready,
    output logic [255:0]               m_req_data,
    output logic [ID_BITS-1:0]         m_req_id,
    input  logic                       ack_valid,
    input  logic [ID_BITS-1:0]         ack_id,
    input  logic                       ack_cmplt,
    output logic [N_ID*CNT_BITS-1:0]   outs_cnt,
    output logic                       err_underflow
);

    localparam int                  CMPLT_BIT = 237;
    localparam logic [CNT_BITS-1:0] CNT_MAX   = CNT_BITS'(MAX_OUTS);
    localparam logic [ID_BITS-1:0]  LAST_RST  = ID_BITS'(N_ID - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t               state_q, state_d;
    logic [255:0]         data_q, data_d;
    logic [ID_BITS-1:0]   id_q, id_d;
    logic [ID_BITS-1:0]   last_q, last_d;
    logic [CNT_BITS-1:0]  cnt_q [N_ID];
    logic [CNT_BITS-1:0]  cnt_d [N_ID];
    logic                 err_q, err_d;

    logic [255:0]         req [N_ID];
    logic [N_ID-1:0]      elig;
    logic [N_ID-1:0]      inc_v, dec_v, unf_v, hit_v;
    logic                 arb_en, grant_vld, load;
    logic [ID_BITS-1:0]   grant_idx;
    int                   cand;

    // Per-requester unpacking, eligibility and completion-counter events.
    // An ack whose id matches no requester never hits, so it is ignored.
    for (genvar i = 0; i < N_ID; i++) begin : g_req
        assign req[i]   = s_req_data[256*i +: 256];
        assign elig[i]  = s_req_valid[i] && (!req[i][CMPLT_BIT] || (cnt_q[i] < CNT_MAX));
        assign inc_v[i] = load && (grant_idx == ID_BITS'(i)) && req[i][CMPLT_BIT];
        assign hit_v[i] = ack_valid && ack_cmplt && (ack_id == ID_BITS'(i));
        assign dec_v[i] = hit_v[i] && (cnt_q[i] != '0);
        assign unf_v[i] = hit_v[i] && (cnt_q[i] == '0);
        assign outs_cnt[CNT_BITS*i +: CNT_BITS] = cnt_q[i];
    end

    // The register can accept a new request when empty or draining this cycle.
    assign arb_en = (state_q == EMPTY) || m_req_ready;
    assign load   = aresetn && arb_en && grant_vld;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 1; k <= N_ID; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N_ID) cand = cand - N_ID;
            if (!grant_vld && elig[cand[ID_BITS-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_BITS-1:0];
            end
        end
    end

    assign s_req_ready = load ? (N_ID'(1) << grant_idx) : '0;

    // Output register next state: load the winner, or empty out on drain.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        if (load) begin
            state_d = FULL;
            data_d  = req[grant_idx];
            id_d    = grant_idx;
            last_d  = grant_idx;
        end else if ((state_q == FULL) && m_req_ready) begin
            state_d = EMPTY;
        end
    end

    // Outstanding counters: a grant and an ack on the same index cancel;
    // saturate at both ends, and flag acks that arrive at zero.
    always_comb begin
        err_d = err_q | (|unf_v);
        for (int i = 0; i < N_ID; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_v[i] && !dec_v[i] && (cnt_q[i] < CNT_MAX))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (dec_v[i] && !inc_v[i])
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= LAST_RST;
            err_q   <= 1'b0;
            for (int i = 0; i < N_ID; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
            err_q   <= err_d;
            for (int i = 0; i < N_ID; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign m_req_valid   = (state_q == FULL);
    assign m_req_data    = data_q;
    assign m_req_id      = id_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_rdma_req_arbiter.sv
// Bench for rdma_req_arbiter: directed scenarios plus biased random traffic,
// all checked every cycle against a transaction-level model.
module tb_rdma_req_arbiter;

    localparam int N   = 4;
    localparam int MO  = 32;
    localparam int IDB = 2;
    localparam int CB  = 6;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      s_req_valid, s_req_ready;
    logic [N*256-1:0]  s_req_data;
    logic              m_req_valid, m_req_ready;
    logic [255:0]      m_req_data;
    logic [IDB-1:0]    m_req_id;
    logic              ack_valid, ack_cmplt;
    logic [IDB-1:0]    ack_id;
    logic [N*CB-1:0]   outs_cnt;
    logic              err_underflow;

    always #5 aclk = ~aclk;

    rdma_req_arbiter #(.N_ID(N), .MAX_OUTS(MO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_data(m_req_data), .m_req_id(m_req_id),
        .ack_valid(ack_valid), .ack_id(ack_id), .ack_cmplt(ack_cmplt),
        .outs_cnt(outs_cnt), .err_underflow(err_underflow)
    );

    // Model: what the output register holds, who was granted last, counts.
    bit           mv;
    logic [255:0] md;
    int           mid, mlast, mcnt[N];
    bit           merr;
    logic [255:0] req[N];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CB-1:0] dut_cnt(input int i);
        return outs_cnt[i*CB +: CB];
    endfunction

    task automatic model_reset();
        mv = 0; md = '0; mid = 0; mlast = N - 1; merr = 0;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
    endtask

    task automatic check_outputs();
        chk("m_req_valid", 256'(m_req_valid), 256'(mv));
        if (mv) begin
            chk("m_req_data", m_req_data, md);
            chk("m_req_id", 256'(m_req_id), 256'(mid));
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("outs_cnt%0d", i), 256'(dut_cnt(i)), 256'(mcnt[i]));
        chk("err_underflow", 256'(err_underflow), 256'(merr));
    endtask

    // One cycle: drive at the falling edge, check the combinational grant,
    // advance the model across the rising edge, check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] cm, input logic rdy,
                        input logic av, input int aid, input logic ac, input logic rst_n);
        int win, c;
        bit canload;
        int old[N];
        logic [N-1:0] exp_rdy;
        for (int i = 0; i < N; i++) begin
            req[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
            req[i][237] = cm[i];
            s_req_data[i*256 +: 256] = req[i];
        end
        s_req_valid = v; m_req_ready = rdy;
        ack_valid = av; ack_id = aid[IDB-1:0]; ack_cmplt = ac;
        aresetn = rst_n;
        #1;
        win = -1;
        canload = !mv || rdy;
        if (rst_n && canload)
            for (int k = 1; k <= N; k++) begin
                c = (mlast + k) % N;
                if (win < 0 && v[c] && (!cm[c] || mcnt[c] < MO)) win = c;
            end
        exp_rdy = (win < 0) ? '0 : N'(1 << win);
        chk("s_req_ready", 256'(s_req_ready), 256'(exp_rdy));
        if (!rst_n) begin
            model_reset();
        end else begin
            old = mcnt;
            if (win >= 0) begin
                mv = 1; md = req[win]; mid = win; mlast = win;
                if (cm[win]) mcnt[win]++;
            end else if (canload) begin
                mv = 0;
            end
            if (av && ac && aid < N) begin
                if (old[aid] > 0) mcnt[aid]--;
                else merr = 1;
            end
        end
        @(negedge aclk);
        check_outputs();
    endtask

    function automatic logic [N-1:0] rbits(input int pct);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 99) < pct);
        return r;
    endfunction

    initial begin
        int grants[5];
        int pv, pc, pr, pa;
        aresetn = 0; s_req_valid = '0; s_req_data = '0; m_req_ready = 0;
        ack_valid = 0; ack_id = '0; ack_cmplt = 0;
        model_reset();
        @(negedge aclk);
        check_outputs();
        step('0, '0, 0, 0, 0, 0, 0);

        // All four valid, always ready: grants 0,1,2,3,0.
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 4'b0000, 1, 0, 0, 0, 1);
            if (s == 0) chk("first_valid", 256'(m_req_valid), 256'(1));
            grants[s] = int'(m_req_id);
        end
        chk("rr_g0", 256'(grants[0]), 256'(0));
        chk("rr_g1", 256'(grants[1]), 256'(1));
        chk("rr_g2", 256'(grants[2]), 256'(2));
        chk("rr_g3", 256'(grants[3]), 256'(3));
        chk("rr_g4", 256'(grants[4]), 256'(0));

        // Back-pressure for 5 cycles: held request is requester 0.
        for (int s = 0; s < 5; s++) step(4'b1111, 4'b1111, 0, 0, 0, 0, 1);
        chk("hold_id", 256'(m_req_id), 256'(0));
        chk("hold_cnt0", 256'(dut_cnt(0)), 256'(0));

        // Requester 1 fills up to MAX_OUTS, then is blocked.
        step('0, '0, 1, 0, 0, 0, 0);
        for (int s = 0; s < 32; s++) step(4'b0010, 4'b0010, 1, 0, 0, 0, 1);
        chk("full_cnt1", 256'(dut_cnt(1)), 256'(32));
        for (int s = 0; s < 3; s++) step(4'b1111, 4'b0010, 1, 0, 0, 0, 1);
        chk("blocked_cnt1", 256'(dut_cnt(1)), 256'(32));
        step(4'b1111, 4'b0010, 1, 1, 1, 1, 1);
        chk("ack_cnt1", 256'(dut_cnt(1)), 256'(31));
        step(4'b0010, 4'b0010, 1, 0, 0, 0, 1);
        chk("regrant_id", 256'(m_req_id), 256'(1));
        chk("regrant_cnt1", 256'(dut_cnt(1)), 256'(32));
        step(4'b0010, 4'b0000, 1, 0, 0, 0, 1);
        chk("nocmplt_id", 256'(m_req_id), 256'(1));
        chk("nocmplt_cnt1", 256'(dut_cnt(1)), 256'(32));

        // Simultaneous grant+ack, underflow, then reset while FULL.
        step('0, '0, 1, 0, 0, 0, 0);
        for (int s = 0; s < 5; s++) step(4'b0100, 4'b0100, 1, 0, 0, 0, 1);
        chk("cnt2_5", 256'(dut_cnt(2)), 256'(5));
        step(4'b0100, 4'b0100, 1, 1, 2, 1, 1);
        chk("cnt2_same", 256'(dut_cnt(2)), 256'(5));
        step('0, '0, 1, 1, 3, 1, 1);
        chk("underflow", 256'(err_underflow), 256'(1));
        chk("cnt3_zero", 256'(dut_cnt(3)), 256'(0));
        step(4'b0100, 4'b0100, 0, 0, 0, 0, 1);
        step(4'b0100, 4'b0100, 1, 0, 0, 0, 1);
        chk("cnt2_7", 256'(dut_cnt(2)), 256'(7));
        chk("sticky", 256'(err_underflow), 256'(1));
        step('0, '0, 0, 0, 0, 0, 0);
        chk("rst_valid", 256'(m_req_valid), 256'(0));
        chk("rst_cnt2", 256'(dut_cnt(2)), 256'(0));
        chk("rst_err", 256'(err_underflow), 256'(0));
        step(4'b1111, 4'b0000, 1, 0, 0, 0, 1);
        chk("rst_first", 256'(m_req_id), 256'(0));

        // Biased random traffic in phases.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin pv = 60; pc = 50; pr = 70; pa = 30; end
                1: begin pv = 90; pc = 95; pr = 95; pa = 5;  end
                2: begin pv = 40; pc = 70; pr = 40; pa = 60; end
                default: begin pv = 80; pc = 90; pr = 80; pa = 15; end
            endcase
            for (int s = 0; s < 1000; s++)
                step(rbits(pv), rbits(pc), ($urandom_range(0, 99) < pr),
                     ($urandom_range(0, 99) < pa), int'($urandom_range(0, N - 1)),
                     ($urandom_range(0, 99) < 80), ($urandom_range(0, 399) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
